// File: rtl/psram_dev.sv
// OPI PSRAM device model: DDR byte-per-edge command/address/wait/data sequencing
// over an internal byte array plus four mode registers (MR0/MR1 wait counts, MR2/MR3 scratch).
module psram_dev #(
  parameter int unsigned MEM_DEPTH = 256,
  parameter logic [7:0]  WR_CMD    = 8'h80,
  parameter logic [7:0]  RD_CMD    = 8'h00,
  parameter logic [7:0]  CFGW_CMD  = 8'hC0,
  parameter logic [7:0]  CFGR_CMD  = 8'h40,
  parameter logic [7:0]  RDW_RST   = 8'd10,
  parameter logic [7:0]  WRW_RST   = 8'd6
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       psram_sck_i,
  input  logic       psram_ce_i,
  input  logic [7:0] psram_io_in_i,
  output logic [7:0] psram_io_out_o,
  output logic [7:0] psram_io_en_o,
  output logic       busy_o
);

  localparam int unsigned AW = $clog2(MEM_DEPTH);

  typedef enum logic [2:0] {
    StIdle, StCmd, StAddr, StWait, StWdata, StRdata, StIgnore
  } state_e;

  state_e      state_q, state_d;
  logic        sck_q;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  op_q, op_d;
  logic [31:0] addr_q, addr_d;
  logic [7:0]  mr_q [4];
  logic [7:0]  mr_d [4];
  logic [7:0]  io_out_q, io_out_d;
  logic [7:0]  io_en_q, io_en_d;
  logic        busy_q, busy_d;
  logic [7:0]  mem_q [MEM_DEPTH];

  logic        bus_edge;
  logic        op_valid, is_wr, is_cfg;
  logic [7:0]  wait_sel;
  logic        mem_we;
  logic [7:0]  rd_byte;
  state_e      data_st;

  // Either sck level change is a bus edge; a deasserted chip enable discards it.
  assign bus_edge = (psram_sck_i != sck_q) && !psram_ce_i;

  always_comb begin
    op_valid = (op_q == WR_CMD) || (op_q == RD_CMD) || (op_q == CFGW_CMD) || (op_q == CFGR_CMD);
    is_wr    = (op_q == WR_CMD) || (op_q == CFGW_CMD);
    is_cfg   = (op_q == CFGW_CMD) || (op_q == CFGR_CMD);
    data_st  = is_wr ? StWdata : StRdata;
    if ((op_q == RD_CMD) || (op_q == CFGR_CMD)) begin
      wait_sel = mr_q[0];
    end else if (op_q == WR_CMD) begin
      wait_sel = mr_q[1];
    end else begin
      wait_sel = 8'd0;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    addr_d  = addr_q;
    mr_d    = mr_q;
    mem_we  = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = 8'd0;
        if (!psram_ce_i) state_d = StCmd;
      end
      StCmd: begin
        if (bus_edge) begin
          if (cnt_q == 8'd0) begin
            op_d  = psram_io_in_i;
            cnt_d = 8'd1;
          end else begin
            cnt_d   = 8'd0;
            state_d = op_valid ? StAddr : StIgnore;
          end
        end
      end
      StAddr: begin
        if (bus_edge) begin
          addr_d = {addr_q[23:0], psram_io_in_i};
          cnt_d  = cnt_q + 8'd1;
          if (cnt_q == 8'd3) begin
            if (wait_sel == 8'd0) begin
              state_d = data_st;
            end else begin
              state_d = StWait;
              cnt_d   = wait_sel;
            end
          end
        end
      end
      StWait: begin
        if (bus_edge) begin
          cnt_d = cnt_q - 8'd1;
          if (cnt_q == 8'd1) state_d = data_st;
        end
      end
      StWdata: begin
        if (bus_edge) begin
          if (is_cfg) mr_d[addr_q[1:0]] = psram_io_in_i;
          else        mem_we = 1'b1;
          addr_d = addr_q + 32'd1;
        end
      end
      StRdata: begin
        if (bus_edge) addr_d = addr_q + 32'd1;
      end
      StIgnore: ;
      default: state_d = StIdle;
    endcase
    if (psram_ce_i) state_d = StIdle;

    // Output byte tracks the post-edge address so it is ready one clk after the edge.
    rd_byte  = is_cfg ? mr_q[addr_d[1:0]] : mem_q[addr_d[AW-1:0]];
    io_out_d = (state_d == StRdata) ? rd_byte : 8'h00;
    io_en_d  = (state_d == StRdata) ? 8'hFF : 8'h00;
    busy_d   = (state_d != StIdle);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= StIdle;
      sck_q    <= 1'b0;
      cnt_q    <= 8'd0;
      op_q     <= 8'd0;
      addr_q   <= 32'd0;
      mr_q[0]  <= RDW_RST;
      mr_q[1]  <= WRW_RST;
      mr_q[2]  <= 8'h00;
      mr_q[3]  <= 8'h00;
      io_out_q <= 8'h00;
      io_en_q  <= 8'h00;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sck_q    <= psram_sck_i;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      mr_q     <= mr_d;
      io_out_q <= io_out_d;
      io_en_q  <= io_en_d;
      busy_q   <= busy_d;
    end
  end

  // Array contents survive reset.
  always_ff @(posedge clk_i) begin
    if (mem_we) mem_q[addr_q[AW-1:0]] <= psram_io_in_i;
  end

  assign psram_io_out_o = io_out_q;
  assign psram_io_en_o  = io_en_q;
  assign busy_o         = busy_q;

endmodule

// File: tb/tb_psram_dev.sv
// Directed bench for psram_dev: driver pushes expected read bytes, a negedge monitor
// pops and compares each byte as the initiator consumes it with a read-data edge.
module tb_psram_dev;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sck;
  logic       ce;
  logic [7:0] io_in;
  logic [7:0] io_out;
  logic [7:0] io_en;
  logic       busy;

  int         n_cmp  = 0;
  int         n_fail = 0;
  logic [7:0] sb_q[$];
  logic       sck_last = 1'b0;

  psram_dev #(.MEM_DEPTH(256)) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .psram_sck_i   (sck),
    .psram_ce_i    (ce),
    .psram_io_in_i (io_in),
    .psram_io_out_o(io_out),
    .psram_io_en_o (io_en),
    .busy_o        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a bus edge seen while the device drives the bus consumes the byte on display.
  always @(negedge clk) begin
    if (rst_n && !ce && io_en === 8'hFF && sck != sck_last) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL rdata_unexpected: got %h expected no read byte at %0t", io_out, $time);
      end else begin
        check("rdata", {24'd0, io_out}, {24'd0, sb_q.pop_front()});
      end
    end
    if (rst_n && io_en !== 8'h00 && io_en !== 8'hFF) check("io_en_legal", {24'd0, io_en}, 32'hFF);
    sck_last = sck;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_byte(input logic [7:0] b);
    io_in = b;
    sck   = ~sck;
    tick();
    tick();
  endtask

  task automatic begin_x();
    ce = 1'b0;
    tick();
    tick();
  endtask

  task automatic end_x();
    ce = 1'b1;
    tick();
    tick();
  endtask

  task automatic hdr(input logic [7:0] op, input logic [31:0] addr, input int nwait);
    bus_byte(op);
    bus_byte(op);
    bus_byte(addr[31:24]);
    bus_byte(addr[23:16]);
    bus_byte(addr[15:8]);
    bus_byte(addr[7:0]);
    for (int i = 0; i < nwait; i++) bus_byte(8'hEE);
  endtask

  task automatic rd(input logic [7:0] exp);
    sb_q.push_back(exp);
    bus_byte(8'h00);
  endtask

  initial begin
    rst_n = 1'b0;
    ce    = 1'b1;
    sck   = 1'b0;
    io_in = 8'h00;
    #1;
    check("rst_io_out", {24'd0, io_out}, 32'h00);
    check("rst_io_en", {24'd0, io_en}, 32'h00);
    check("rst_busy", {31'd0, busy}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Write A5 5A at 0x10 with default 6 write waits.
    begin_x();
    hdr(8'h80, 32'h0000_0010, 6);
    check("wr_busy", {31'd0, busy}, 32'd1);
    check("wr_io_en", {24'd0, io_en}, 32'h00);
    bus_byte(8'hA5);
    bus_byte(8'h5A);
    end_x();
    check("idle_busy", {31'd0, busy}, 32'd0);

    // Read back with default 10 read waits.
    begin_x();
    hdr(8'h00, 32'h0000_0010, 10);
    check("rd_io_en", {24'd0, io_en}, 32'hFF);
    rd(8'hA5);
    rd(8'h5A);
    end_x();
    check("rd_end_io_en", {24'd0, io_en}, 32'h00);

    // Array index wraps at MEM_DEPTH.
    begin_x();
    hdr(8'h80, 32'h0000_00FF, 6);
    bus_byte(8'h11);
    bus_byte(8'h22);
    end_x();
    begin_x();
    hdr(8'h00, 32'h0000_00FF, 10);
    rd(8'h11);
    rd(8'h22);
    end_x();
    begin_x();
    hdr(8'h00, 32'h0000_0000, 10);
    rd(8'h22);
    end_x();

    // Mode registers: MR1 reads 06, then MR0 <= 2, MR2/MR3 scratch.
    begin_x();
    hdr(8'h40, 32'h0000_0001, 10);
    rd(8'h06);
    end_x();
    begin_x();
    hdr(8'hC0, 32'h0000_0000, 0);
    bus_byte(8'h02);
    end_x();
    begin_x();
    hdr(8'hC0, 32'h0000_0002, 0);
    bus_byte(8'h5C);
    bus_byte(8'h3C);
    end_x();
    begin_x();
    hdr(8'h00, 32'h0000_0010, 2);
    check("mr0_short_io_en", {24'd0, io_en}, 32'hFF);
    rd(8'hA5);
    end_x();
    begin_x();
    hdr(8'h40, 32'h0000_0000, 2);
    rd(8'h02);
    rd(8'h06);
    rd(8'h5C);
    rd(8'h3C);
    rd(8'h02);
    end_x();

    // Bad opcode: everything ignored until ce rises.
    begin_x();
    bus_byte(8'h33);
    bus_byte(8'h33);
    bus_byte(8'h00);
    bus_byte(8'h00);
    bus_byte(8'h00);
    bus_byte(8'h10);
    for (int i = 0; i < 6; i++) bus_byte(8'hFF);
    check("bad_io_en", {24'd0, io_en}, 32'h00);
    check("bad_busy", {31'd0, busy}, 32'd1);
    end_x();
    check("bad_idle", {31'd0, busy}, 32'd0);
    begin_x();
    hdr(8'h00, 32'h0000_0010, 2);
    rd(8'hA5);
    rd(8'h5A);
    end_x();

    // Abort mid write burst: committed byte stays, next location untouched.
    begin_x();
    hdr(8'h80, 32'h0000_0020, 6);
    bus_byte(8'h01);
    bus_byte(8'h02);
    end_x();
    begin_x();
    hdr(8'h80, 32'h0000_0020, 6);
    bus_byte(8'h77);
    ce = 1'b1;
    tick();
    check("abort_busy", {31'd0, busy}, 32'd0);
    tick();
    begin_x();
    hdr(8'h00, 32'h0000_0020, 2);
    rd(8'h77);
    rd(8'h02);
    end_x();

    // Reset pulsed in WAIT: outputs clear at once, MR0 returns to 10.
    begin_x();
    hdr(8'h00, 32'h0000_0010, 1);
    check("wait_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rstw_busy", {31'd0, busy}, 32'd0);
    check("rstw_io_en", {24'd0, io_en}, 32'h00);
    check("rstw_io_out", {24'd0, io_out}, 32'h00);
    ce = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    begin_x();
    hdr(8'h00, 32'h0000_0010, 10);
    rd(8'hA5);
    end_x();

    check("sb_drained", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
